// File: rtl/pq_expiry_dispatcher_pkg.sv
// Shared types for the priority-queue expiry dispatcher: cell layout,
// dispatcher FSM states and the wrap-safe deadline comparison.
package pq_expiry_dispatcher_pkg;

  localparam int QUEUE_DEPTH = 16;
  localparam int TIME_WIDTH  = 32;
  localparam int ID_WIDTH    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_WIDTH   = $clog2(QUEUE_DEPTH + 1);

  typedef logic [TIME_WIDTH-1:0] time_t;

  typedef struct packed {
    time_t               data;
    logic [ID_WIDTH-1:0] id;
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    OUT,
    SETTLE
  } dispatch_state_e;

  // Deadline has passed (or is now) when now - deadline is non-negative in
  // modulo arithmetic; valid for deadlines less than half the range ahead.
  function automatic logic time_expired(input time_t now, input time_t deadline);
    time_t diff;
    diff = now - deadline;
    return ~diff[TIME_WIDTH-1];
  endfunction

endpackage

// File: rtl/pq_timebase.sv
// Free-running timebase: counts while enabled, wraps naturally, and can be
// loaded with an absolute value (load wins over counting).
module pq_timebase #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] now_o
);

  logic [W-1:0] now_q, now_d;

  // Next time value: load, increment, or hold.
  always_comb begin
    now_d = now_q;
    if (load_i) begin
      now_d = load_val_i;
    end else if (en_i) begin
      now_d = now_q + W'(1);
    end
  end

  // Time register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      now_q <= '0;
    end else begin
      now_q <= now_d;
    end
  end

  assign now_o = now_q;

endmodule

// File: rtl/pq_expiry_dispatcher.sv
// Expiry dispatcher: watches the priority-queue head against a local
// timebase, pops expired cells and offers them on a valid/ready port.
// Optional lateness reporting is built when PQ_DISPATCH_LATENESS_EN is defined.
module pq_expiry_dispatcher
  import pq_expiry_dispatcher_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  en_i,
  input  logic                  time_load_i,
  input  logic [TIME_WIDTH-1:0] time_val_i,
  output logic [TIME_WIDTH-1:0] now_o,
  input  cell_t                 pq_head_i,
  input  logic                  pq_head_valid_i,
  output logic                  pq_pop_o,
  input  logic                  pq_ready_i,
  output cell_t                 evt_o,
  output logic                  evt_valid_o,
`ifdef PQ_DISPATCH_LATENESS_EN
  output logic [TIME_WIDTH-1:0] late_o,
  output logic [TIME_WIDTH-1:0] late_max_o,
`endif
  input  logic                  evt_ready_i
);

  logic [TIME_WIDTH-1:0] now_q;
  dispatch_state_e       state_q, state_d;
  cell_t                 evt_q, evt_d;
  logic                  pop_q, pop_d;
  logic                  expired;
  logic                  launch;

  pq_timebase #(.W(TIME_WIDTH)) u_timebase (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .load_i     (time_load_i),
    .load_val_i (time_val_i),
    .now_o      (now_q)
  );

  // Compare uses the pre-load time, so a same-cycle load never masks expiry.
  assign expired = pq_head_valid_i && time_expired(now_q, pq_head_i.data);

  // Dispatch FSM: pop on expiry, hold the cell until accepted, then give the
  // queue at least one cycle to present a fresh head before looking again.
  always_comb begin
    state_d = state_q;
    evt_d   = evt_q;
    pop_d   = 1'b0;
    launch  = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i && expired && pq_ready_i) begin
          launch  = 1'b1;
          evt_d   = pq_head_i;
          pop_d   = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (evt_ready_i) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (pq_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, captured cell and pop strobe registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      evt_q   <= '0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      pop_q   <= pop_d;
    end
  end

  assign now_o       = now_q;
  assign pq_pop_o    = pop_q;
  assign evt_o       = evt_q;
  assign evt_valid_o = (state_q == OUT);

`ifdef PQ_DISPATCH_LATENESS_EN
  logic [TIME_WIDTH-1:0] late_q, late_d;
  logic [TIME_WIDTH-1:0] late_max_q, late_max_d;

  // Lateness of the cell being launched, and the running worst case.
  always_comb begin
    late_d     = late_q;
    late_max_d = late_max_q;
    if (launch) begin
      late_d = now_q - pq_head_i.data;
      if (late_d > late_max_q) begin
        late_max_d = late_d;
      end
    end
  end

  // Lateness registers, held alongside the captured cell.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      late_q     <= '0;
      late_max_q <= '0;
    end else begin
      late_q     <= late_d;
      late_max_q <= late_max_d;
    end
  end

  assign late_o     = late_q;
  assign late_max_o = late_max_q;
`endif

endmodule

// File: tb/tb_pq_expiry_dispatcher.sv
// Directed bench for pq_expiry_dispatcher with a pop-driven scoreboard.
module tb_pq_expiry_dispatcher;
  import pq_expiry_dispatcher_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  en;
  logic                  time_load;
  logic [TIME_WIDTH-1:0] time_val;
  logic [TIME_WIDTH-1:0] now;
  cell_t                 head;
  logic                  head_valid;
  logic                  pq_pop;
  logic                  pq_ready;
  cell_t                 evt;
  logic                  evt_valid;
  logic                  evt_ready;
`ifdef PQ_DISPATCH_LATENESS_EN
  logic [TIME_WIDTH-1:0] late;
  logic [TIME_WIDTH-1:0] late_max;
`endif

  always #5 clk = ~clk;

  pq_expiry_dispatcher dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .time_load_i     (time_load),
    .time_val_i      (time_val),
    .now_o           (now),
    .pq_head_i       (head),
    .pq_head_valid_i (head_valid),
    .pq_pop_o        (pq_pop),
    .pq_ready_i      (pq_ready),
    .evt_o           (evt),
    .evt_valid_o     (evt_valid),
`ifdef PQ_DISPATCH_LATENESS_EN
    .late_o          (late),
    .late_max_o      (late_max),
`endif
    .evt_ready_i     (evt_ready)
  );

  typedef struct {
    logic [TIME_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   id;
    logic [TIME_WIDTH-1:0] now;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s: %0h", name, act);
    end
  endfunction

  function automatic void expect_evt(input logic [TIME_WIDTH-1:0] d,
                                     input logic [ID_WIDTH-1:0] id,
                                     input logic [TIME_WIDTH-1:0] n);
    exp_t e;
    e.data = d;
    e.id   = id;
    e.now  = n;
    sb_q.push_back(e);
  endfunction

  // Monitor: every pop strobe must match the next expected dispatch.
  always @(negedge clk) begin
    exp_t e;
    if (pq_pop === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pop", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("evt_data", 64'(evt.data), 64'(e.data));
        check("evt_id", 64'(evt.id), 64'(e.id));
        check("pop_now", 64'(now), 64'(e.now));
        check("pop_valid", 64'(evt_valid), 64'd1);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pop(input int budget, input string name, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (cycles < budget && !seen) begin
      cyc();
      cycles++;
      if (pq_pop === 1'b1) seen = 1'b1;
    end
    if (!seen) check({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    int c;
    rst        = 1'b1;
    en         = 1'b0;
    time_load  = 1'b0;
    time_val   = '0;
    head       = '0;
    head_valid = 1'b0;
    pq_ready   = 1'b0;
    evt_ready  = 1'b0;
    repeat (2) cyc();

    // Reset state
    check("rst_now", 64'(now), 64'd0);
    check("rst_pop", 64'(pq_pop), 64'd0);
    check("rst_valid", 64'(evt_valid), 64'd0);
    check("rst_evt", 64'(evt), 64'd0);

    // T1: head {10,3} dispatches when now reaches 10
    rst        = 1'b0;
    en         = 1'b1;
    head.data  = 32'd10;
    head.id    = 3;
    head_valid = 1'b1;
    pq_ready   = 1'b1;
    evt_ready  = 1'b1;
    expect_evt(32'd10, 3, 32'd11);
    wait_pop(40, "t1", c);
    check("t1_cycles", 64'(c), 64'd11);
    head_valid = 1'b0;
    cyc();
    check("t1_single_pulse", 64'(pq_pop), 64'd0);
    cyc();

    // T2: downstream stalls 5 cycles; cell held, head changes ignored
    head.data  = 32'd20;
    head.id    = 7;
    head_valid = 1'b1;
    evt_ready  = 1'b0;
    expect_evt(32'd20, 7, 32'd21);
    wait_pop(40, "t2", c);
    head.data = 32'd0;
    head.id   = 9;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_hold_valid", 64'(evt_valid), 64'd1);
      check("t2_hold_data", 64'(evt.data), 64'd20);
      check("t2_hold_id", 64'(evt.id), 64'd7);
      check("t2_no_pop", 64'(pq_pop), 64'd0);
    end
    head_valid = 1'b0;
    evt_ready  = 1'b1;
    cyc();
    check("t2_handshake", 64'(evt_valid), 64'd0);
    cyc();

    // T3: timebase wraps from FFFF_FFF0 to deadline 4
    time_load = 1'b1;
    time_val  = 32'hFFFF_FFF0;
    cyc();
    time_load = 1'b0;
    check("t3_load", 64'(now), 64'hFFFF_FFF0);
    head.data  = 32'd4;
    head.id    = 2;
    head_valid = 1'b1;
    expect_evt(32'd4, 2, 32'd5);
    wait_pop(40, "t3", c);
    check("t3_cycles", 64'(c), 64'd21);
    head_valid = 1'b0;
    repeat (2) cyc();

    // T4: already-late head dispatches immediately
    time_load = 1'b1;
    time_val  = 32'd200;
    cyc();
    time_load  = 1'b0;
    head.data  = 32'd100;
    head.id    = 5;
    head_valid = 1'b1;
    expect_evt(32'd100, 5, 32'd201);
    cyc();
    check("t4_immediate", 64'(pq_pop), 64'd1);
`ifdef PQ_DISPATCH_LATENESS_EN
    check("t4_late", 64'(late), 64'd100);
    check("t4_late_max", 64'(late_max), 64'd100);
`endif
    head_valid = 1'b0;
    repeat (2) cyc();

    // T5: queue busy blocks the pop until pq_ready rises
    time_load = 1'b1;
    time_val  = 32'd300;
    cyc();
    time_load  = 1'b0;
    pq_ready   = 1'b0;
    evt_ready  = 1'b0;
    head.data  = 32'd150;
    head.id    = 6;
    head_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t5_blocked", 64'(pq_pop), 64'd0);
    end
    pq_ready = 1'b1;
    expect_evt(32'd150, 6, 32'd305);
    cyc();
    check("t5_pop", 64'(pq_pop), 64'd1);
`ifdef PQ_DISPATCH_LATENESS_EN
    check("t5_late_max", 64'(late_max), 64'd154);
`endif

    // T6: reset while presenting an event
    cyc();
    check("t6_still_out", 64'(evt_valid), 64'd1);
    rst = 1'b1;
    cyc();
    check("t6_rst_valid", 64'(evt_valid), 64'd0);
    check("t6_rst_now", 64'(now), 64'd0);
    check("t6_rst_pop", 64'(pq_pop), 64'd0);
    check("t6_rst_evt", 64'(evt), 64'd0);
`ifdef PQ_DISPATCH_LATENESS_EN
    check("t6_rst_late_max", 64'(late_max), 64'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("t6_no_pop", 64'(pq_pop), 64'd0);
      check("t6_idle", 64'(evt_valid), 64'd0);
    end
    head_valid = 1'b0;
    cyc();
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
